// File: rtl/mem_bus_ctrl_if.sv
// Load/store-unit side of the memory bus controller.
// The master is the LS unit; the slave is mem_bus_ctrl.
interface mem_bus_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_u_b_h_w;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_u_b_h_w,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Address decode, byte-lane steering and MMIO state (LED, keyboard FIFO, timer).
// Reads are combinational; all state commits on negedge clk, when the LS unit samples rdata.
module mem_bus_ctrl #(
  parameter int RAM_AW    = 12,
  parameter int VRAM_AW   = 13,
  parameter int KBD_DEPTH = 8,
  parameter int TIMER_DIV = 100
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_ctrl_if.slave      bus,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [3:0]         ram_we,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [31:0]        vram_wdata,
  input  logic               kbd_valid,
  input  logic [7:0]         kbd_data,
  output logic [15:0]        led,
  output logic               fault,
  output logic [31:0]        fault_addr
);

  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int PW  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);
  localparam logic [KAW:0]  KBD_FULL = (KAW + 1)'(KBD_DEPTH);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] R_LED  = 2'd0;
  localparam logic [1:0] R_KDAT = 2'd1;
  localparam logic [1:0] R_KSTA = 2'd2;
  localparam logic [1:0] R_TMR  = 2'd3;

  logic [31:0] a;
  logic [31:0] wd;
  logic [1:0]  sz;
  logic        uns;
  logic [1:0]  reg_sel;
  assign a       = bus.mem_addr;
  assign wd      = bus.mem_wdata;
  assign sz      = bus.mem_u_b_h_w[1:0];
  assign uns     = bus.mem_u_b_h_w[2];
  assign reg_sel = a[3:2];

  // ---------------------------------------------------------------- decode
  logic ram_hit, vram_hit, mmio_hit, is_w, aligned, legal, access;
  logic fault_now, do_wr, do_rd;

  assign ram_hit  = (a[31:RAM_AW+2] == '0);
  assign vram_hit = (a[31:28] == 4'hE) && (a[27:VRAM_AW+2] == '0);
  assign mmio_hit = (a[31:4] == 28'hF00_0000);
  assign is_w     = (sz == SZ_W);
  assign aligned  = (sz == SZ_B) ||
                    ((sz == SZ_H) && !a[0]) ||
                    (is_w && (a[1:0] == 2'b00));
  // MMIO and VRAM only accept full-word accesses.
  assign legal     = aligned && (ram_hit || ((vram_hit || mmio_hit) && is_w));
  assign access    = bus.mem_read || bus.mem_write;
  assign fault_now = access && !legal;
  assign do_wr     = bus.mem_write && legal;
  assign do_rd     = bus.mem_read && !bus.mem_write && legal;

  // ------------------------------------------------------- store steering
  logic [3:0] lane_sel;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    always_comb begin
      lane_sel[l]        = 1'b1;
      ram_wdata[8*l +: 8] = wd[8*l +: 8];
      if (sz == SZ_B) begin
        lane_sel[l]         = (a[1:0] == LN);
        ram_wdata[8*l +: 8] = wd[7:0];
      end else if (sz == SZ_H) begin
        lane_sel[l]         = (a[1] == LN[1]);
        ram_wdata[8*l +: 8] = LN[0] ? wd[15:8] : wd[7:0];
      end
    end
  end

  assign ram_addr   = a[RAM_AW+1:2];
  assign ram_we     = (do_wr && ram_hit) ? lane_sel : 4'b0000;
  assign vram_addr  = a[VRAM_AW+1:2];
  assign vram_we    = do_wr && vram_hit;
  assign vram_wdata = wd;

  // ------------------------------------------------------------ MMIO state
  logic [7:0]     kbd_mem [KBD_DEPTH];
  logic [KAW-1:0] kbd_wptr, kbd_rptr;
  logic [KAW:0]   kbd_cnt;
  logic           kbd_ovf;
  logic [31:0]    timer;
  logic [PW-1:0]  presc;

  logic kbd_nonempty, kbd_full, kbd_pop, kbd_push, ovf_set, ovf_clr;
  logic led_wr, tmr_wr, tick;
  logic [3:0] cnt4;

  assign kbd_nonempty = (kbd_cnt != '0);
  assign kbd_full     = (kbd_cnt == KBD_FULL);
  assign kbd_pop      = do_rd && mmio_hit && (reg_sel == R_KDAT) && kbd_nonempty;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign kbd_push     = kbd_valid && (!kbd_full || kbd_pop);
  assign ovf_set      = kbd_valid && kbd_full && !kbd_pop;
  assign ovf_clr      = do_wr && mmio_hit && (reg_sel == R_KSTA);
  assign led_wr       = do_wr && mmio_hit && (reg_sel == R_LED);
  assign tmr_wr       = do_wr && mmio_hit && (reg_sel == R_TMR);
  assign tick         = (presc == PRE_MAX);
  assign cnt4         = 4'(kbd_cnt);

  always_ff @(negedge clk) begin
    if (kbd_push) kbd_mem[kbd_wptr] <= kbd_data;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      led        <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
      kbd_wptr   <= '0;
      kbd_rptr   <= '0;
      kbd_cnt    <= '0;
      kbd_ovf    <= 1'b0;
      timer      <= '0;
      presc      <= '0;
    end else begin
      if (fault_now && !fault) begin
        fault      <= 1'b1;
        fault_addr <= a;
      end
      if (led_wr) led <= wd[15:0];

      if (kbd_push) kbd_wptr <= kbd_wptr + 1'b1;
      if (kbd_pop)  kbd_rptr <= kbd_rptr + 1'b1;
      case ({kbd_push, kbd_pop})
        2'b10:   kbd_cnt <= kbd_cnt + 1'b1;
        2'b01:   kbd_cnt <= kbd_cnt - 1'b1;
        default: kbd_cnt <= kbd_cnt;
      endcase
      kbd_ovf <= (kbd_ovf && !ovf_clr) || ovf_set;

      if (tmr_wr) begin
        timer <= wd;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) timer <= timer + 32'd1;
      end
    end
  end

  // ------------------------------------------------------------- read path
  logic [31:0] src, shifted, ext;

  always_comb begin
    src = '0;
    if (ram_hit) begin
      src = ram_rdata;
    end else if (mmio_hit) begin
      case (reg_sel)
        R_LED:   src = {16'h0, led};
        R_KDAT:  src = kbd_nonempty ? {24'h0, kbd_mem[kbd_rptr]} : 32'h0;
        R_KSTA:  src = {24'h0, cnt4, 2'b00, kbd_ovf, kbd_nonempty};
        default: src = timer;
      endcase
    end
  end

  assign shifted = src >> {a[1:0], 3'b000};

  always_comb begin
    case (sz)
      SZ_B:    ext = {{24{!uns && shifted[7]}}, shifted[7:0]};
      SZ_H:    ext = {{16{!uns && shifted[15]}}, shifted[15:0]};
      default: ext = src;
    endcase
  end

  assign bus.mem_rdata = do_rd ? ext : 32'h0;

endmodule
